vid_pattern_gen: RTL and testbench

VID_PATTERN_GEN -- requirements
Module: vid_pattern_gen

---
 rtl/vid_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_vid_pattern_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vid_pattern_gen.sv
// Video timing and test-pattern generator: raster counters with start/stop
// frame control, followed by one registered decode stage for sync/DE/pixel.
module vid_pattern_gen #(
  parameter logic [11:0] IMG_HDISP    = 12'd1280,
  parameter logic [11:0] IMG_VDISP    = 12'd720,
  parameter logic [11:0] H_TOTAL      = 12'd1650,
  parameter logic [11:0] V_TOTAL      = 12'd750,
  parameter logic [11:0] V_SYNC_START = 12'd725,
  parameter logic [11:0] V_SYNC_LEN   = 12'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  output logic        post_vs,
  output logic        post_de,
  output logic [23:0] post_data,
  output logic        frame_done
);

  localparam logic [11:0] H_LAST = H_TOTAL - 12'd1;
  localparam logic [11:0] V_LAST = V_TOTAL - 12'd1;
  localparam logic [12:0] VS_END = {1'b0, V_SYNC_START} + {1'b0, V_SYNC_LEN};

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  typedef struct packed {
    logic        vs;
    logic        de;
    logic [23:0] data;
    logic        done;
  } pix_t;

  state_e      state_q, state_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [1:0]  mode_q, mode_d;
  pix_t        pix_q, pix_d;

  logic        h_last, frame_end;

  assign h_last    = (hcnt_q == H_LAST);
  assign frame_end = h_last && (vcnt_q == V_LAST);

  // Mode is captured on every edge that moves the raster onto (0,0), so a
  // whole frame is always drawn with a single pattern.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    fcnt_d  = fcnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        fcnt_d = '0;
        if (en) begin
          state_d = S_RUN;
          mode_d  = mode;
        end
      end
      S_RUN: begin
        if (frame_end) begin
          hcnt_d = '0;
          vcnt_d = '0;
          fcnt_d = fcnt_q + 8'd1;
          mode_d = mode;
          if (!en) state_d = S_IDLE;
        end else if (h_last) begin
          hcnt_d = '0;
          vcnt_d = vcnt_q + 12'd1;
        end else begin
          hcnt_d = hcnt_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic [23:0] bar_colour(input logic [2:0] b);
    case (b)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  logic [14:0] hx8;
  logic [2:0]  bar_idx;
  logic        active, vs_hit;
  logic [23:0] pattern;

  // Bar index floor(hcnt*8/IMG_HDISP) as a count of crossed thresholds
  // k*IMG_HDISP; thresholds are constants, so this is seven comparators.
  always_comb begin
    hx8     = {hcnt_q, 3'b000};
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (hx8 >= 15'(k) * {3'b000, IMG_HDISP}) bar_idx = bar_idx + 3'd1;
    end
    active = (hcnt_q < IMG_HDISP) && (vcnt_q < IMG_VDISP);
    vs_hit = ({1'b0, vcnt_q} >= {1'b0, V_SYNC_START}) && ({1'b0, vcnt_q} < VS_END);
    case (mode_q)
      2'b00:   pattern = 24'h808080;
      2'b01:   pattern = bar_colour(bar_idx);
      2'b10:   pattern = {hcnt_q[7:0], vcnt_q[7:0], fcnt_q};
      default: pattern = (hcnt_q[5] ^ vcnt_q[5]) ? 24'h000000 : 24'hFFFFFF;
    endcase
    pix_d = '0;
    if (state_q == S_RUN) begin
      pix_d.vs   = vs_hit;
      pix_d.de   = active;
      pix_d.done = frame_end;
      pix_d.data = active ? pattern : 24'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      fcnt_q  <= '0;
      mode_q  <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      fcnt_q  <= fcnt_d;
      mode_q  <= mode_d;
      pix_q   <= pix_d;
    end
  end

  assign post_vs    = pix_q.vs;
  assign post_de    = pix_q.de;
  assign post_data  = pix_q.data;
  assign frame_done = pix_q.done;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Bench for vid_pattern_gen: cycle-index reference model compared every clock,
// plus literal checks of the small-raster scenarios.
module tb_vid_pattern_gen;

  localparam int HD = 16, VD = 4, HT = 20, VT = 8, VSS = 5, VSL = 1;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        post_vs, post_de, frame_done;
  logic [23:0] post_data;

  vid_pattern_gen #(
    .IMG_HDISP(12'(HD)), .IMG_VDISP(12'(VD)), .H_TOTAL(12'(HT)),
    .V_TOTAL(12'(VT)), .V_SYNC_START(12'(VSS)), .V_SYNC_LEN(12'(VSL))
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .post_vs(post_vs), .post_de(post_de), .post_data(post_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        vs;
    logic        de;
    logic [23:0] data;
    logic        done;
  } px_t;

  function automatic logic [23:0] bar_ref(input int b);
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return tbl[b];
  endfunction

  // Expected output for the t-th clock since the run started.
  function automatic px_t model_px(input int t, input logic [1:0] md);
    px_t r;
    int p, h, v, f;
    p = t % FR; h = p % HT; v = p / HT; f = (t / FR) % 256;
    r = '0;
    r.de   = (h < HD) && (v < VD);
    r.vs   = (v >= VSS) && (v < VSS + VSL);
    r.done = (p == FR - 1);
    if (r.de) begin
      case (md)
        2'd0: r.data = 24'h808080;
        2'd1: r.data = bar_ref((h * 8) / HD);
        2'd2: r.data = {8'(h), 8'(v), 8'(f)};
        default: r.data = (((h / 32) + (v / 32)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      endcase
    end
    return r;
  endfunction

  px_t        e;
  int         e_h, e_v;
  bit         m_run;
  int         m_t;
  logic [1:0] m_mode;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= '0; e_h <= 0; e_v <= 0; m_run <= 1'b0; m_t <= 0; m_mode <= 2'b00;
    end else if (m_run) begin
      e   <= model_px(m_t, m_mode);
      e_h <= (m_t % FR) % HT;
      e_v <= (m_t % FR) / HT;
      if ((m_t % FR == FR - 1) && !en) m_run <= 1'b0;
      else begin
        m_t <= m_t + 1;
        if (m_t % FR == FR - 1) m_mode <= mode;
      end
    end else begin
      e <= '0;
      if (en) begin
        m_run <= 1'b1; m_t <= 0; m_mode <= mode;
      end
    end
  end

  int          cyc = 0, de_cnt = 0, vs_cnt = 0, run_len = 0;
  int          runs[$];
  int          done_cyc[$];
  logic [23:0] dut_pix [0:HD-1][0:VD-1];

  always @(negedge clk) begin
    chk("vs", 32'(post_vs), 32'(e.vs));
    chk("de", 32'(post_de), 32'(e.de));
    chk("data", 32'(post_data), 32'(e.data));
    chk("frame_done", 32'(frame_done), 32'(e.done));
    cyc    <= cyc + 1;
    de_cnt <= de_cnt + int'(post_de);
    vs_cnt <= vs_cnt + int'(post_vs);
    if (post_de) run_len <= run_len + 1;
    else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len <= 0;
    end
    if (frame_done) done_cyc.push_back(cyc);
    if (e.de) dut_pix[e_h][e_v] <= post_data;
  end

  task automatic wait_t(input int target);
    int n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (!(m_run && m_t >= target) && n < 3000);
    if (n >= 3000) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_vs"}, 32'(post_vs), 32'd0);
    chk({nm, "_de"}, 32'(post_de), 32'd0);
    chk({nm, "_data"}, 32'(post_data), 32'd0);
    chk({nm, "_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int d0, v0, r0, q0, n;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // Two solid frames: DE runs, VS count, frame_done spacing.
    en = 1'b1; mode = 2'b00;
    d0 = de_cnt; v0 = vs_cnt; r0 = runs.size(); q0 = done_cyc.size();
    repeat (2 * FR + 2) @(posedge clk);
    #2;
    chk("de_clocks_2fr", 32'(de_cnt - d0), 32'd128);
    chk("vs_clocks_2fr", 32'(vs_cnt - v0), 32'd40);
    chk("de_runs_2fr", 32'(runs.size() - r0), 32'd8);
    for (int i = r0; i < runs.size(); i++) chk("de_run_len", 32'(runs[i]), 32'd16);
    chk("done_pulses_2fr", 32'(done_cyc.size() - q0), 32'd2);
    if (done_cyc.size() >= q0 + 2)
      chk("done_period", 32'(done_cyc[q0+1] - done_cyc[q0]), 32'd160);

    // Colour bars take effect from the next frame start (frame 3).
    mode = 2'b01;
    wait_t(3 * FR + 2 * HT);
    @(negedge clk); #1;
    for (int h = 0; h < HD; h++) chk("bar_pixel", 32'(dut_pix[h][1]), 32'(bars[h / 2]));

    // Stop request during line 1: frame completes with one frame_done.
    wait_t(4 * FR + HT);
    en = 1'b0;
    q0 = done_cyc.size();
    n = 0;
    while (m_run && n < 500) begin
      @(posedge clk); n++;
    end
    if (n >= 500) chk("stop_timeout", 32'd0, 32'd1);
    repeat (12) @(posedge clk);
    #2;
    chk("stop_done_once", 32'(done_cyc.size() - q0), 32'd1);
    chk_zero("idle");

    // Gradient from a fresh start: blue carries the frame number.
    mode = 2'b10; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_t(k * FR + 3 * HT);
      @(negedge clk); #1;
      chk("grad_5_2", 32'(dut_pix[5][2]), 32'h050200 + 32'(k));
    end

    // Mid-frame switch to checker only shows up on the following frame.
    mode = 2'b00;
    wait_t(3 * FR + 2 * HT);
    mode = 2'b11;
    wait_t(3 * FR + 4 * HT);
    @(negedge clk); #1;
    for (int v = 2; v < VD; v++)
      for (int h = 0; h < HD; h++) chk("solid_after_switch", 32'(dut_pix[h][v]), 32'h808080);
    wait_t(4 * FR + 1);
    @(negedge clk); #1;
    chk("checker_0_0", 32'(dut_pix[0][0]), 32'hFFFFFF);

    // Asynchronous reset at (h=7, v=3), then restart two clocks to first pixel.
    wait_t(5 * FR + 3 * HT + 7);
    rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_de_1clk", 32'(post_de), 32'd0);
    @(posedge clk); #1;
    chk("restart_de_2clk", 32'(post_de), 32'd1);
    chk("restart_data", 32'(post_data), 32'hFFFFFF);

    // Random enable/mode traffic, checked every clock by the model.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
    end
    en = 1'b0;
    repeat (2 * FR) @(posedge clk);
    #2 chk_zero("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
